// File: rtl/flag_table_pkg.sv
// Shared types and helpers for the valid_flag_table slot-flag store.
// Optional feature macro used by the top: FLAG_FWD_EN (write-first bypass).
package flag_table_pkg;

  typedef enum logic {ST_SWEEP, ST_IDLE} flag_state_t;

  localparam int FT_MAX_SLOTS = 32;

  // Index width for a slot number; at least one bit so BUCKET_SIZE=1 still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest clear bit of a flag word padded with ones above the real slots; 0 when all set.
  function automatic logic [4:0] first_zero(input logic [FT_MAX_SLOTS-1:0] v);
    first_zero = '0;
    for (int i = FT_MAX_SLOTS-1; i >= 0; i--)
      if (!v[i]) first_zero = 5'(i);
  endfunction

endpackage

// File: rtl/flag_slot_decode.sv
// Per-read-port encoder: bucket-full flag and index of the first free slot.
module flag_slot_decode
  import flag_table_pkg::*;
#(
  parameter int BUCKET_SIZE = 4,
  parameter int IDX_W       = idx_w(BUCKET_SIZE)
) (
  input  logic [BUCKET_SIZE-1:0] flags,
  output logic                   full,
  output logic [IDX_W-1:0]       free_idx
);

  logic [FT_MAX_SLOTS-1:0] padded;

  always_comb begin
    padded                  = '1;
    padded[BUCKET_SIZE-1:0] = flags;
  end

  assign full     = &flags;
  assign free_idx = IDX_W'(first_zero(padded));

endmodule

// File: rtl/valid_flag_table.sv
// Multi-port per-bucket slot-valid flag store with sequenced clear sweep.
// Define FLAG_FWD_EN for write-first bypass of same-cycle read/write; default is read-first.
module valid_flag_table
  import flag_table_pkg::*;
#(
  parameter int SIZE        = 10,
  parameter int BUCKET_SIZE = 4,
  parameter int NUM_READ    = 3,
  parameter int CLEAR_LANES = 4
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [NUM_READ-1:0][SIZE-1:0]                 read_adr,
  input  logic                                          write_en,
  input  logic [SIZE-1:0]                               write_adr,
  input  logic [BUCKET_SIZE-1:0]                        write_set,
  input  logic [BUCKET_SIZE-1:0]                        write_clr,
  input  logic                                          clear_req,
  output logic                                          busy,
  output logic [NUM_READ-1:0][BUCKET_SIZE-1:0]          flag_out,
  output logic [NUM_READ-1:0][idx_w(BUCKET_SIZE)-1:0]   free_idx,
  output logic [NUM_READ-1:0]                           full
);

  localparam int DEPTH = 1 << SIZE;
  localparam int IDX_W = idx_w(BUCKET_SIZE);

  // No per-entry reset: the sweep zeroes the array before any read is honoured.
  logic [BUCKET_SIZE-1:0] flag_mem [DEPTH];

  flag_state_t state_q, state_d;
  logic        busy_q, busy_d;
  logic [SIZE-1:0] sweep_ptr_q, sweep_ptr_d;

  logic [NUM_READ-1:0][BUCKET_SIZE-1:0] flag_q, flag_d;
  logic [NUM_READ-1:0][IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_READ-1:0]                  full_q, full_d;

  logic                   last_grp;
  logic                   wr_acc;
  logic [BUCKET_SIZE-1:0] wr_val;

  assign last_grp = (sweep_ptr_q == SIZE'(DEPTH - CLEAR_LANES));
  assign wr_acc   = write_en & ~busy_q;
  assign wr_val   = (flag_mem[write_adr] & ~write_clr) | write_set;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    sweep_ptr_d = sweep_ptr_q;
    case (state_q)
      ST_SWEEP: begin
        sweep_ptr_d = sweep_ptr_q + SIZE'(CLEAR_LANES);
        if (last_grp) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          sweep_ptr_d = '0;
        end
      end
      default: begin
        if (clear_req) begin
          state_d     = ST_SWEEP;
          busy_d      = 1'b1;
          sweep_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SWEEP;
      busy_q      <= 1'b1;
      sweep_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      sweep_ptr_q <= sweep_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (busy_q) begin
      for (int l = 0; l < CLEAR_LANES; l++)
        flag_mem[sweep_ptr_q + SIZE'(l)] <= '0;
    end else if (wr_acc) begin
      flag_mem[write_adr] <= wr_val;
    end
  end

  logic [BUCKET_SIZE-1:0] rd_val   [NUM_READ];
  logic                   dec_full [NUM_READ];
  logic [IDX_W-1:0]       dec_idx  [NUM_READ];

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
`ifdef FLAG_FWD_EN
    assign rd_val[p] = (wr_acc && (read_adr[p] == write_adr)) ? wr_val
                                                               : flag_mem[read_adr[p]];
`else
    assign rd_val[p] = flag_mem[read_adr[p]];
`endif
    flag_slot_decode #(.BUCKET_SIZE(BUCKET_SIZE), .IDX_W(IDX_W)) u_dec (
      .flags    (rd_val[p]),
      .full     (dec_full[p]),
      .free_idx (dec_idx[p])
    );
  end

  always_comb begin
    flag_d = '0;
    idx_d  = '0;
    full_d = '0;
    if (!busy_q) begin
      for (int p = 0; p < NUM_READ; p++) begin
        flag_d[p] = rd_val[p];
        idx_d[p]  = dec_idx[p];
        full_d[p] = dec_full[p];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= '0;
      idx_q  <= '0;
      full_q <= '0;
    end else begin
      flag_q <= flag_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  assign busy     = busy_q;
  assign flag_out = flag_q;
  assign free_idx = idx_q;
  assign full     = full_q;

endmodule

// File: tb/tb_valid_flag_table.sv
// Directed + random bench for valid_flag_table against a whole-table reference model.
module tb_valid_flag_table;

  localparam int SIZE  = 4;
  localparam int BS    = 4;
  localparam int NR    = 3;
  localparam int CL    = 4;
  localparam int DEPTH = 1 << SIZE;
  localparam int IW    = 2;
  localparam int SWEEP_CYC = DEPTH / CL;
`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b1;
  logic [NR-1:0][SIZE-1:0]    read_adr;
  logic                       write_en;
  logic [SIZE-1:0]            write_adr;
  logic [BS-1:0]              write_set, write_clr;
  logic                       clear_req;
  logic                       busy;
  logic [NR-1:0][BS-1:0]      flag_out;
  logic [NR-1:0][IW-1:0]      free_idx;
  logic [NR-1:0]              full;

  valid_flag_table #(.SIZE(SIZE), .BUCKET_SIZE(BS), .NUM_READ(NR), .CLEAR_LANES(CL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .read_adr  (read_adr),
    .write_en  (write_en),
    .write_adr (write_adr),
    .write_set (write_set),
    .write_clr (write_clr),
    .clear_req (clear_req),
    .busy      (busy),
    .flag_out  (flag_out),
    .free_idx  (free_idx),
    .full      (full)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Model: table contents plus remaining sweep cycles; a sweep simply empties the table.
  logic [BS-1:0] model [DEPTH];
  int            sweep_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_free(input logic [BS-1:0] v);
    for (int i = 0; i < BS; i++)
      if (!v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    sweep_left = SWEEP_CYC;
  endtask

  task automatic idle_in();
    write_en  = 1'b0;
    write_adr = '0;
    write_set = '0;
    write_clr = '0;
    clear_req = 1'b0;
  endtask

  // One clock: predict from current inputs, advance model, then compare after the edge.
  task automatic cycle();
    bit            busy_now, wr;
    logic [BS-1:0] nv;
    logic [BS-1:0] ex [NR];
    busy_now = (sweep_left > 0);
    wr       = write_en && !busy_now;
    nv       = (model[write_adr] & ~write_clr) | write_set;
    for (int p = 0; p < NR; p++) begin
      if (busy_now)                                   ex[p] = '0;
      else if (FWD && wr && read_adr[p] == write_adr) ex[p] = nv;
      else                                            ex[p] = model[read_adr[p]];
    end
    if (wr) model[write_adr] = nv;
    if (busy_now) sweep_left--;
    else if (clear_req) begin
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      sweep_left = SWEEP_CYC;
    end
    @(posedge clk); #1;
    check("busy", 32'(busy), 32'(sweep_left > 0));
    for (int p = 0; p < NR; p++) begin
      check($sformatf("flag_out[%0d]", p), 32'(flag_out[p]), 32'(ex[p]));
      check($sformatf("full[%0d]", p), 32'(full[p]), 32'(!busy_now && ex[p] == '1));
      check($sformatf("free_idx[%0d]", p), 32'(free_idx[p]), busy_now ? 32'd0 : 32'(ref_free(ex[p])));
    end
  endtask

  task automatic wait_sweep(input string tag);
    int bc = 0;
    while (busy && bc < 20) begin
      cycle();
      bc++;
    end
    check(tag, 32'(bc), 32'(SWEEP_CYC));
  endtask

  task automatic wr(input int a, input int s, input int c);
    write_en  = 1'b1;
    write_adr = SIZE'(a);
    write_set = BS'(s);
    write_clr = BS'(c);
  endtask

  initial begin
    idle_in();
    read_adr = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_flag", 32'(flag_out), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_free", 32'(free_idx), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_sweep("busy_len_reset");

    // Every address reads empty after the sweep
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = 0; p < NR; p++) read_adr[p] = SIZE'((a + p) % DEPTH);
      cycle();
    end

    // Set/clear read-modify-write on adr 5
    wr(5, 4'b0101, 0); cycle();
    wr(5, 4'b0010, 4'b0001); cycle();
    idle_in(); read_adr[0] = SIZE'(5); cycle();
    check("adr5_flag", 32'(flag_out[0]), 32'b0110);
    check("adr5_free", 32'(free_idx[0]), 32'd0);

    // Full bucket on all ports; set wins over clear
    wr(7, 4'b1111, 0); cycle();
    idle_in(); for (int p = 0; p < NR; p++) read_adr[p] = SIZE'(7); cycle();
    check("adr7_full_all", 32'(full), 32'b111);
    wr(7, 4'b1000, 4'b1000); cycle();
    idle_in(); cycle();
    check("adr7_setwins", 32'(flag_out[1]), 32'hF);

    // Same-cycle read/write on adr 3
    wr(3, 4'b0001, 0); read_adr[0] = SIZE'(3); cycle();
    check("adr3_same_cycle", 32'(flag_out[0]), FWD ? 32'd1 : 32'd0);
    idle_in(); cycle();
    check("adr3_next", 32'(flag_out[0]), 32'd1);

    // Clear sweep on request; write during busy is dropped
    wr(2, 4'b0011, 0); cycle();
    wr(9, 4'b1110, 0); cycle();
    idle_in(); clear_req = 1'b1; cycle();
    clear_req = 1'b0; wr(9, 4'b1111, 0);
    wait_sweep("busy_len_clear");
    idle_in(); read_adr[0] = SIZE'(2); read_adr[1] = SIZE'(9); read_adr[2] = SIZE'(9); cycle();
    check("adr9_after_clear", 32'(flag_out[1]), 32'd0);

    // Reset mid-sweep at sweep_ptr=8
    wr(7, 4'b0110, 0); cycle();
    idle_in(); clear_req = 1'b1; cycle();
    clear_req = 1'b0; cycle(); cycle();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_flag", 32'(flag_out), 32'd0);
    model_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    wait_sweep("busy_len_midrst");
    read_adr[0] = SIZE'(7); cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      write_en  = 1'($urandom_range(0, 1));
      write_adr = SIZE'($urandom_range(0, DEPTH-1));
      write_set = BS'($urandom & $urandom);
      write_clr = BS'($urandom);
      clear_req = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < NR; p++)
        read_adr[p] = ($urandom_range(0, 3) == 0) ? write_adr : SIZE'($urandom_range(0, DEPTH-1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
